readback_controller: RTL and testbench

Device-side read path for the LED matrix serial command interface. It decodes the read command (0x0B) from the received byte stream and issues prefetching word reads to the frame-buffer memory port. It then serializes the returned pixel words into bytes for the host-facing byte shifter. It is the return-direction counterpart of the write/configuration command path and shares the same cs_n-framed byte protocol.

---
 rtl/readback_controller.sv | 183 ++++++++++++++++++
 tb/tb_readback_controller.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/readback_controller.sv
// readback_controller: decodes the 0x0B read command, prefetches frame-buffer words and serializes them to tx bytes
// Ports: clk_sys, reset_n (sync, active-low); cs_n transaction frame; data_in/data_in_ready received bytes;
//   color_format pixel size; tx_load/tx_byte/tx_valid byte shifter side; address_mem/rd_mem/fifo_full_mem/
//   data_in_mem/data_in_ready_mem memory read port; underrun, busy status.
// Optional feature: define READBACK_HEADER_EN to send 0x5A ahead of the read data.
module readback_controller #(
    parameter int ADDRESS_WIDTH  = 25,
    parameter int DATA_WIDTH     = 16,
    parameter int PREFETCH_DEPTH = 4
) (
    input  logic                     clk_sys,
    input  logic                     reset_n,
    input  logic                     cs_n,
    input  logic [7:0]               data_in,
    input  logic                     data_in_ready,
    input  logic                     color_format,
    input  logic                     tx_load,
    output logic [7:0]               tx_byte,
    output logic                     tx_valid,
    output logic [ADDRESS_WIDTH-1:0] address_mem,
    output logic                     rd_mem,
    input  logic                     fifo_full_mem,
    input  logic [DATA_WIDTH-1:0]    data_in_mem,
    input  logic                     data_in_ready_mem,
    output logic                     underrun,
    output logic                     busy
);
    localparam int PW = $clog2(PREFETCH_DEPTH);
    localparam int CW = PW + 1;
    typedef enum logic [1:0] {IDLE, ADDR, STREAM, DONE} state_t;
    state_t state, state_n;
    logic cs_m, cs_s;
    logic [1:0] bcnt;
    logic [23:0] addr_sr;
    logic [31:0] addr_full;
    logic [ADDRESS_WIDTH-1:0] rd_addr;
    logic fmt, half, hdr;
    logic [CW-1:0] outstanding, discard, fifo_count;
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [DATA_WIDTH-1:0] fifo_mem [PREFETCH_DEPTH];
    logic [DATA_WIDTH-1:0] head, nxt;
    logic abort, enter_stream, issue, push, pop, more;

    function automatic logic [7:0] pick(input logic [15:0] w, input logic hi);
        return hi ? w[15:8] : w[7:0];
    endfunction

    assign abort        = cs_s;
    assign addr_full    = {addr_sr, data_in};
    assign enter_stream = state == ADDR && data_in_ready && bcnt == 2'd3 && !abort;
    // Budget counts words already queued plus words still in flight, so the FIFO cannot overflow.
    assign issue = state == STREAM && !abort && !fifo_full_mem && discard == '0 &&
                   ({1'b0, fifo_count} + {1'b0, outstanding}) < (CW+1)'(PREFETCH_DEPTH);
    // Responses owed to an aborted transaction are swallowed while discard is nonzero.
    assign push  = data_in_ready_mem && discard == '0 && state == STREAM && !abort;
    assign pop   = tx_load && tx_valid && !hdr && (!fmt || half);
    assign head  = fifo_mem[rd_ptr];
    // Next word after a pop; bypass the incoming response when it lands in the slot being exposed.
    assign more  = fifo_count > CW'(1) || push;
    assign nxt   = fifo_count > CW'(1) ? fifo_mem[rd_ptr + PW'(1)] : data_in_mem;
    assign busy  = state != IDLE || outstanding != '0;

    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            cs_m <= 1'b1;
            cs_s <= 1'b1;
        end else begin
            cs_m <= cs_n;
            cs_s <= cs_m;
        end
    end

    always_ff @(posedge clk_sys) state <= !reset_n ? IDLE : state_n;

    always_comb begin
        state_n = state;
        if (abort)
            state_n = IDLE;
        else if (data_in_ready) begin
            case (state)
                IDLE:    state_n = data_in == 8'h0B ? ADDR : DONE;
                ADDR:    state_n = bcnt == 2'd3 ? STREAM : ADDR;
                default: state_n = state;
            endcase
        end
    end

    always_ff @(posedge clk_sys) begin
        if (!reset_n || abort) begin
            bcnt    <= '0;
            addr_sr <= '0;
        end else if (state == ADDR && data_in_ready) begin
            bcnt    <= bcnt + 2'd1;
            addr_sr <= addr_full[23:0];
        end
    end

    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            rd_addr     <= '0;
            address_mem <= '0;
            rd_mem      <= 1'b0;
            fmt         <= 1'b0;
        end else begin
            rd_mem <= issue;
            if (enter_stream) begin
                rd_addr <= addr_full[ADDRESS_WIDTH-1:0];
                fmt     <= color_format;
            end else if (issue) begin
                address_mem <= rd_addr;
                rd_addr     <= rd_addr + ADDRESS_WIDTH'(1);
            end
        end
    end

    // outstanding is counted at issue time and deliberately survives abort.
    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            outstanding <= '0;
            discard     <= '0;
        end else begin
            outstanding <= outstanding + CW'(issue) - CW'(data_in_ready_mem);
            if (abort)
                discard <= outstanding - CW'(data_in_ready_mem);
            else if (data_in_ready_mem && discard != '0)
                discard <= discard - CW'(1);
        end
    end

    always_ff @(posedge clk_sys) begin
        if (!reset_n || abort) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + PW'(1);
            if (pop)
                rd_ptr <= rd_ptr + PW'(1);
            fifo_count <= fifo_count + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk_sys) if (push) fifo_mem[wr_ptr] <= data_in_mem;

    // The word being transmitted stays at the FIFO head until its last byte is taken.
    always_ff @(posedge clk_sys) begin
        if (!reset_n || abort) begin
            tx_byte  <= '0;
            tx_valid <= 1'b0;
            half     <= 1'b0;
            hdr      <= 1'b0;
            underrun <= 1'b0;
        end else begin
            if (tx_load && !tx_valid)
                underrun <= 1'b1;
`ifdef READBACK_HEADER_EN
            if (enter_stream) begin
                tx_byte  <= 8'h5A;
                tx_valid <= 1'b1;
                hdr      <= 1'b1;
            end else
`endif
            if (tx_load && tx_valid) begin
                if (hdr) begin
                    hdr      <= 1'b0;
                    tx_valid <= fifo_count != '0;
                    tx_byte  <= fifo_count != '0 ? pick(head, fmt) : 8'h00;
                end else if (!pop) begin
                    half    <= 1'b1;
                    tx_byte <= head[7:0];
                end else begin
                    half     <= 1'b0;
                    tx_valid <= more;
                    tx_byte  <= more ? pick(nxt, fmt) : 8'h00;
                end
            end else if (!tx_valid && fifo_count != '0 && state == STREAM) begin
                tx_valid <= 1'b1;
                tx_byte  <= pick(head, fmt);
            end
        end
    end
endmodule

// File: tb/tb_readback_controller.sv
// tb_readback_controller: directed checks of readback_controller against a latency-2 memory model
module tb_readback_controller;
    logic        clk_sys = 1'b0;
    logic        reset_n, cs_n, data_in_ready, color_format, tx_load;
    logic [7:0]  data_in, tx_byte;
    logic        tx_valid, rd_mem, fifo_full_mem, data_in_ready_mem, underrun, busy;
    logic [24:0] address_mem;
    logic [15:0] data_in_mem;

    int vectors = 0;
    int miscompares = 0;
    int mem_allow = -1;
    int cyc = 0;
    logic [15:0] mem [int];
    logic [24:0] addr_log [$];
    logic [24:0] pend_a [$];
    int          pend_t [$];

    readback_controller dut (
        .clk_sys(clk_sys), .reset_n(reset_n), .cs_n(cs_n), .data_in(data_in),
        .data_in_ready(data_in_ready), .color_format(color_format), .tx_load(tx_load),
        .tx_byte(tx_byte), .tx_valid(tx_valid), .address_mem(address_mem), .rd_mem(rd_mem),
        .fifo_full_mem(fifo_full_mem), .data_in_mem(data_in_mem),
        .data_in_ready_mem(data_in_ready_mem), .underrun(underrun), .busy(busy)
    );

    always #5 clk_sys = ~clk_sys;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, required finish");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [15:0] rdmem(input logic [24:0] a);
        return mem.exists(int'(a)) ? mem[int'(a)] : 16'hDEAD;
    endfunction

    // Memory: requests answered in order, two cycles later, while mem_allow permits.
    initial begin
        data_in_ready_mem = 1'b0;
        data_in_mem = '0;
        forever begin
            @(posedge clk_sys);
            #1;
            data_in_ready_mem = 1'b0;
            if (!reset_n) begin
                pend_a.delete();
                pend_t.delete();
            end else begin
                if (rd_mem) begin
                    pend_a.push_back(address_mem);
                    pend_t.push_back(cyc);
                    addr_log.push_back(address_mem);
                end
                if (pend_a.size() > 0 && cyc - pend_t[0] >= 2 && mem_allow != 0) begin
                    data_in_ready_mem = 1'b1;
                    data_in_mem = rdmem(pend_a.pop_front());
                    void'(pend_t.pop_front());
                    if (mem_allow > 0) mem_allow--;
                end
            end
            cyc++;
        end
    end

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        data_in = b;
        data_in_ready = 1'b1;
        tick();
        data_in_ready = 1'b0;
        repeat (3) tick();
    endtask

    task automatic start_cmd(input logic fmt, input logic [31:0] a);
        color_format = fmt;
        cs_n = 1'b0;
        repeat (3) tick();
        send_byte(8'h0B);
        for (int i = 3; i >= 0; i--) send_byte(a[i*8 +: 8]);
    endtask

    task automatic pop_byte(input string tag, input logic [7:0] exp);
        for (int i = 0; i < 64 && !tx_valid; i++) tick();
        chk({tag, "_valid"}, tx_valid, 1);
        chk(tag, tx_byte, exp);
        tx_load = 1'b1;
        tick();
        tx_load = 1'b0;
        repeat (8) tick();
    endtask

    task automatic finish_txn(input string tag);
        cs_n = 1'b1;
        repeat (4) tick();
        for (int i = 0; i < 64 && busy; i++) tick();
        chk({tag, "_idle"}, busy, 0);
        chk({tag, "_txv"}, tx_valid, 0);
    endtask

    initial begin
        reset_n = 1'b0;
        cs_n = 1'b1;
        data_in = '0;
        data_in_ready = 1'b0;
        color_format = 1'b0;
        tx_load = 1'b0;
        fifo_full_mem = 1'b0;
        mem[32'h10] = 16'h1234;
        mem[32'h11] = 16'hABCD;
        mem[32'h0] = 16'h00AA;
        mem[32'h1] = 16'h00BB;
        mem[32'h100] = 16'h1177;
        mem[32'h20] = 16'h00E0;
        mem[32'h21] = 16'h00E1;
        mem[32'h22] = 16'h00E2;
        mem[32'h23] = 16'h00E3;
        mem[32'h40] = 16'h0055;
        repeat (3) tick();
        chk("rst_tx_byte", tx_byte, 0);
        chk("rst_tx_valid", tx_valid, 0);
        chk("rst_address", address_mem, 0);
        chk("rst_rd_mem", rd_mem, 0);
        chk("rst_underrun", underrun, 0);
        chk("rst_busy", busy, 0);
        reset_n = 1'b1;
        repeat (2) tick();

        start_cmd(1'b1, 32'h10);
`ifdef READBACK_HEADER_EN
        pop_byte("t1_hdr", 8'h5A);
`endif
        pop_byte("t1_b0", 8'h12);
        pop_byte("t1_b1", 8'h34);
        pop_byte("t1_b2", 8'hAB);
        pop_byte("t1_b3", 8'hCD);
        finish_txn("t1");

        addr_log.delete();
        start_cmd(1'b0, 32'h0);
        repeat (20) tick();
        chk("t2_nreq", addr_log.size(), 4);
        for (int i = 0; i < 4; i++) chk("t2_addr", addr_log[i], i);
`ifdef READBACK_HEADER_EN
        pop_byte("t2_hdr", 8'h5A);
`endif
        pop_byte("t2_b0", 8'hAA);
        chk("t2_nreq_pop", addr_log.size(), 5);
        chk("t2_addr4", addr_log[4], 4);
        pop_byte("t2_b1", 8'hBB);
        finish_txn("t2");

        addr_log.delete();
        start_cmd(1'b0, 32'hFFFF_FFFF);
        repeat (20) tick();
        chk("t3_addr0", addr_log[0], 25'h1FF_FFFF);
        chk("t3_wrap", addr_log[1], 0);
        finish_txn("t3");

        addr_log.delete();
        fifo_full_mem = 1'b1;
        start_cmd(1'b0, 32'h100);
`ifdef READBACK_HEADER_EN
        pop_byte("t4_hdr", 8'h5A);
`endif
        repeat (20) tick();
        chk("t4_no_req", addr_log.size(), 0);
        chk("t4_txv", tx_valid, 0);
        tx_load = 1'b1;
        tick();
        tx_load = 1'b0;
        chk("t4_underrun", underrun, 1);
        chk("t4_tx_byte", tx_byte, 0);
        repeat (8) tick();
        fifo_full_mem = 1'b0;
        repeat (10) tick();
        chk("t4_resume", addr_log.size(), 4);
        chk("t4_addr0", addr_log[0], 25'h100);
        pop_byte("t4_b0", 8'h77);
        chk("t4_sticky", underrun, 1);
        cs_n = 1'b1;
        repeat (4) tick();
        chk("t4_ur_clr", underrun, 0);
        finish_txn("t4");

        addr_log.delete();
        mem_allow = 0;
        start_cmd(1'b0, 32'h20);
        repeat (10) tick();
        chk("t5_nreq", addr_log.size(), 4);
        mem_allow = 1;
        repeat (6) tick();
        chk("t5_nreq_hold", addr_log.size(), 4);
        cs_n = 1'b1;
        repeat (4) tick();
        chk("t5_busy_abort", busy, 1);
        chk("t5_txv_abort", tx_valid, 0);
        start_cmd(1'b0, 32'h40);
        repeat (10) tick();
        chk("t5_blocked", addr_log.size(), 4);
        chk("t5_busy", busy, 1);
        mem_allow = -1;
`ifdef READBACK_HEADER_EN
        pop_byte("t5_hdr", 8'h5A);
`endif
        pop_byte("t5_b0", 8'h55);
        chk("t5_addr_new", addr_log[4], 25'h40);
        finish_txn("t5");

        addr_log.delete();
        cs_n = 1'b0;
        repeat (3) tick();
        send_byte(8'h14);
        send_byte(8'h0B);
        send_byte(8'h00);
        repeat (20) tick();
        chk("t6_no_req", addr_log.size(), 0);
        chk("t6_txv", tx_valid, 0);
        chk("t6_busy", busy, 1);
        finish_txn("t6");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
